// File: rtl/ssd_scan_driver_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package ssd_pkg;

  // Conversion FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  typedef logic [3:0] bcd_nibble_t;

  localparam bcd_nibble_t BCD_MAX_DIGIT = 4'd9;
  localparam logic        ANODE_OFF     = 1'b1;

  // Largest value representable on 'digits' decimal digits (10^digits - 1).
  // Evaluated at elaboration time only.
  function automatic logic [63:0] bcd_max_value(input int unsigned digits);
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Handshake/display bus between the CPU/debug feeder and the scan driver.
// Latency: n/a (wires only).
// Backpressure: load is ignored while busy is high; there is no queueing.
// Ports: bin_value/load (requester -> driver); busy, overflow, ssd_data,
// an, digit_idx (driver -> requester/decoder).
interface ssd_scan_driver_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [WIDTH-1:0]  bin_value;
  logic              load;
  logic              busy;
  logic              overflow;
  logic [3:0]        ssd_data;
  logic [DIGITS-1:0] an;
  logic [IDX_W-1:0]  digit_idx;

  // Requester side (CPU/debug path, testbench)
  modport master (
    output bin_value, load,
    input  busy, overflow, ssd_data, an, digit_idx
  );

  // Scan driver side
  modport slave (
    input  bin_value, load,
    output busy, overflow, ssd_data, an, digit_idx
  );
endinterface

// File: rtl/ssd_scan_driver_bcd_add3_shift.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd_i/bin_i current accumulator and binary shift register; bcd_o/bin_o next values.
module bcd_add3_shift
  import ssd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic [DIGITS*4-1:0] bcd_i,
  input  logic [WIDTH-1:0]    bin_i,
  output logic [DIGITS*4-1:0] bcd_o,
  output logic [WIDTH-1:0]    bin_o
);

  logic [DIGITS*4-1:0] adj;
  // The top accumulator bit falls off the shift; for in-range values it is
  // always zero, and out-of-range values are replaced at commit anyway.
  logic                unused_msb;

  always_comb begin
    bcd_nibble_t nib;
    adj = bcd_i;
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcd_i[i*4 +: 4];
      if (nib >= 4'd5) begin
        adj[i*4 +: 4] = nib + 4'd3;
      end
    end
  end

  assign unused_msb = adj[DIGITS*4-1];
  assign {bcd_o, bin_o} = {adj[DIGITS*4-2:0], bin_i, 1'b0};

endmodule

// File: rtl/ssd_scan_driver.sv
// Binary-to-BCD converter (iterative double-dabble) plus multiplexed 7-seg digit scan.
// Latency: display updates WIDTH+2 cycles after the accepted load edge (busy high WIDTH+1 cycles).
// Backpressure: loads are dropped while busy; the scan runs free regardless of the converter.
// Ports: clk, reset (async, active-high); bus (slave modport): bin_value, load in;
// busy, overflow, ssd_data, an (active-low), digit_idx out.
// Optional: define SSD_SCAN_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int WIDTH       = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  ssd_scan_driver_if.slave  bus
);

  localparam int                IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int                CNT_W   = $clog2(REFRESH_DIV);
  localparam int                BCD_W   = DIGITS * 4;
  localparam logic [63:0]       MAX_VAL = bcd_max_value(DIGITS);
  localparam logic [DIGITS-1:0] AN_RST  = ~DIGITS'(1);

  // Converter state
  conv_state_e        state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [WIDTH-1:0]   iter_q, iter_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               overflow_q, overflow_d;

  // Scan state
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [3:0]         data_q, data_d;

  logic [BCD_W-1:0]   bcd_step;
  logic [WIDTH-1:0]   bin_step;

`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]  blank_q, blank_d;
`endif

  bcd_add3_shift #(
    .DIGITS (DIGITS),
    .WIDTH  (WIDTH)
  ) u_step (
    .bcd_i (bcd_q),
    .bin_i (bin_q),
    .bcd_o (bcd_step),
    .bin_o (bin_step)
  );

  // Conversion FSM
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d      = bus.bin_value;
          bcd_d      = '0;
          iter_d     = '0;
          // Decided on the latched value so later bin_value changes cannot affect it
          ovf_pend_d = (64'(bus.bin_value) > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bin_d  = bin_step;
        bcd_d  = bcd_step;
        iter_d = iter_q + 1'b1;
        if (iter_q == WIDTH'(WIDTH - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (ovf_pend_q) begin
          disp_d     = {DIGITS{BCD_MAX_DIGIT}};
          overflow_d = 1'b1;
        end else begin
          disp_d     = bcd_q;
          overflow_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more-significant digit are zero.
  // disp_d equals disp_q outside COMMIT, so the mask only changes on commit.
  always_comb begin
    logic run;
    blank_d = '0;
    run     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run        = run & (disp_d[i*4 +: 4] == 4'd0);
      blank_d[i] = run;
    end
  end
`endif

  // Refresh scan. an/ssd_data are looked up from the next-state index and
  // display so a commit coinciding with a digit advance never shows a mix.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    an_d   = ~(DIGITS'(1) << idx_d);
    data_d = disp_d[int'(idx_d)*4 +: 4];
`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
    if (blank_d[idx_d]) begin
      an_d   = {DIGITS{ANODE_OFF}};
      data_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= AN_RST;
      data_q     <= '0;
`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
      blank_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      data_q     <= data_d;
`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.overflow  = overflow_q;
  assign bus.ssd_data  = data_q;
  assign bus.an        = an_q;
  assign bus.digit_idx = idx_q;

endmodule
